// File: rtl/kbd_key_tracker_pkg.sv
// Shared scan-code constants and FSM state encoding for the keyboard key tracker.
package kbd_key_tracker_pkg;

    localparam logic [7:0] CODE_E0     = 8'hE0;
    localparam logic [7:0] CODE_F0     = 8'hF0;
    localparam logic [7:0] CODE_CAPS   = 8'h58;
    localparam logic [7:0] CODE_LSHIFT = 8'h12;
    localparam logic [7:0] CODE_RSHIFT = 8'h59;

    typedef enum logic [1:0] {
        StWait   = 2'd0,
        StPop    = 2'd1,
        StDecode = 2'd2
    } state_e;

endpackage

// File: rtl/kbd_key_tracker_rom.sv
// Scan code (set 2) to unshifted ASCII lookup; unmapped codes read as 0.
module kbd_key_tracker_rom (
    input  logic [7:0] code,
    output logic [7:0] ascii
);

    // Combinational 256-entry table, default 0.
    always_comb begin
        ascii = 8'h00;
        case (code)
            8'h1C: ascii = 8'h61; 8'h32: ascii = 8'h62; 8'h21: ascii = 8'h63;
            8'h23: ascii = 8'h64; 8'h24: ascii = 8'h65; 8'h2B: ascii = 8'h66;
            8'h34: ascii = 8'h67; 8'h33: ascii = 8'h68; 8'h43: ascii = 8'h69;
            8'h3B: ascii = 8'h6A; 8'h42: ascii = 8'h6B; 8'h4B: ascii = 8'h6C;
            8'h3A: ascii = 8'h6D; 8'h31: ascii = 8'h6E; 8'h44: ascii = 8'h6F;
            8'h4D: ascii = 8'h70; 8'h15: ascii = 8'h71; 8'h2D: ascii = 8'h72;
            8'h1B: ascii = 8'h73; 8'h2C: ascii = 8'h74; 8'h3C: ascii = 8'h75;
            8'h2A: ascii = 8'h76; 8'h1D: ascii = 8'h77; 8'h22: ascii = 8'h78;
            8'h35: ascii = 8'h79; 8'h1A: ascii = 8'h7A;
            8'h45: ascii = 8'h30; 8'h16: ascii = 8'h31; 8'h1E: ascii = 8'h32;
            8'h26: ascii = 8'h33; 8'h25: ascii = 8'h34; 8'h2E: ascii = 8'h35;
            8'h36: ascii = 8'h36; 8'h3D: ascii = 8'h37; 8'h3E: ascii = 8'h38;
            8'h46: ascii = 8'h39;
            8'h29: ascii = 8'h20; 8'h5A: ascii = 8'h0D; 8'h66: ascii = 8'h08;
            8'h0D: ascii = 8'h09; 8'h76: ascii = 8'h1B; 8'h0E: ascii = 8'h60;
            8'h4E: ascii = 8'h2D; 8'h55: ascii = 8'h3D; 8'h54: ascii = 8'h5B;
            8'h5B: ascii = 8'h5D; 8'h5D: ascii = 8'h5C; 8'h4C: ascii = 8'h3B;
            8'h52: ascii = 8'h27; 8'h41: ascii = 8'h2C; 8'h49: ascii = 8'h2E;
            8'h4A: ascii = 8'h2F;
            default: ascii = 8'h00;
        endcase
    end

endmodule

// File: rtl/kbd_key_tracker.sv
// PS/2 byte-stream decoder: pops bytes from the receiver FIFO (3 cycles per byte) and tracks
// the held key, shift, caps-lock and a wrapping press counter for the display panel.
module kbd_key_tracker
    import kbd_key_tracker_pkg::*;
#(
    parameter int unsigned COUNT_MAX   = 99,
    parameter logic [7:0]  CAPS_CODE   = CODE_CAPS,
    parameter logic [7:0]  LSHIFT_CODE = CODE_LSHIFT,
    parameter logic [7:0]  RSHIFT_CODE = CODE_RSHIFT
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       rx_ready,
    input  logic [7:0] rx_data,
    output logic       rx_next_n,
    output logic [7:0] data_out,
    output logic       pre,
    output logic [7:0] ascii_out,
    output logic [7:0] count,
    output logic       capslock,
    output logic       shift
);

    localparam logic [7:0] CountMax = 8'(COUNT_MAX);

    state_e     state_q, state_d;
    logic [7:0] byte_q, byte_d;
    logic       next_n_q, next_n_d;
    logic [7:0] data_q, data_d;
    logic [7:0] key_q, key_d;
    logic [7:0] count_q, count_d;
    logic       pre_q, pre_d;
    logic       brk_q, brk_d;
    logic       ext_q, ext_d;
    logic       caps_q, caps_d;
    logic       lshift_q, lshift_d;
    logic       rshift_q, rshift_d;
    logic       new_press;

    // FSM state register.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state_q <= StWait;
        else       state_q <= state_d;
    end

    // FSM next state: wait for a byte, spend one cycle popping, one decoding.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StWait:   if (rx_ready) state_d = StPop;
            StPop:    state_d = StDecode;
            StDecode: state_d = StWait;
            default:  state_d = StWait;
        endcase
    end

    assign new_press = !pre_q || (byte_q != key_q);

    // FSM outputs: pop strobe, byte latch and the decode of prefixes/make/break.
    always_comb begin
        byte_d   = byte_q;
        next_n_d = 1'b1;
        data_d   = data_q;
        key_d    = key_q;
        count_d  = count_q;
        pre_d    = pre_q;
        brk_d    = brk_q;
        ext_d    = ext_q;
        caps_d   = caps_q;
        lshift_d = lshift_q;
        rshift_d = rshift_q;
        unique case (state_q)
            StWait: begin
                if (rx_ready) begin
                    byte_d   = rx_data;
                    next_n_d = 1'b0;
                end
            end
            StDecode: begin
                if (byte_q == CODE_E0) begin
                    ext_d = 1'b1;
                end else if (byte_q == CODE_F0) begin
                    brk_d  = 1'b1;
                    data_d = CODE_F0;
                end else if (brk_q) begin
                    brk_d = 1'b0;
                    ext_d = 1'b0;
                    // Releasing some other key puts the held key back on the display.
                    if (byte_q == key_q) begin
                        pre_d  = 1'b0;
                        data_d = byte_q;
                    end else begin
                        data_d = key_q;
                    end
                    if (!ext_q && byte_q == LSHIFT_CODE) lshift_d = 1'b0;
                    if (!ext_q && byte_q == RSHIFT_CODE) rshift_d = 1'b0;
                end else begin
                    ext_d  = 1'b0;
                    data_d = byte_q;
                    // Typematic repeats of the held key are not new presses.
                    if (new_press) begin
                        key_d   = byte_q;
                        pre_d   = 1'b1;
                        count_d = (count_q == CountMax) ? 8'd0 : count_q + 8'd1;
                        if (byte_q == CAPS_CODE) caps_d = !caps_q;
                    end
                    // E0 12 is a fake shift and must not set the flag.
                    if (!ext_q && byte_q == LSHIFT_CODE) lshift_d = 1'b1;
                    if (!ext_q && byte_q == RSHIFT_CODE) rshift_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset also discards any pending break/extended prefix.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            byte_q   <= 8'h00;
            next_n_q <= 1'b1;
            data_q   <= 8'h00;
            key_q    <= 8'h00;
            count_q  <= 8'h00;
            pre_q    <= 1'b0;
            brk_q    <= 1'b0;
            ext_q    <= 1'b0;
            caps_q   <= 1'b0;
            lshift_q <= 1'b0;
            rshift_q <= 1'b0;
        end else begin
            byte_q   <= byte_d;
            next_n_q <= next_n_d;
            data_q   <= data_d;
            key_q    <= key_d;
            count_q  <= count_d;
            pre_q    <= pre_d;
            brk_q    <= brk_d;
            ext_q    <= ext_d;
            caps_q   <= caps_d;
            lshift_q <= lshift_d;
            rshift_q <= rshift_d;
        end
    end

    kbd_key_tracker_rom u_rom (
        .code  (key_q),
        .ascii (ascii_out)
    );

    assign rx_next_n = next_n_q;
    assign data_out  = data_q;
    assign pre       = pre_q;
    assign count     = count_q;
    assign capslock  = caps_q;
    assign shift     = lshift_q | rshift_q;

endmodule

// File: tb/tb_kbd_key_tracker.sv
// Directed bench for kbd_key_tracker: FIFO model feeds bytes, a reference model pushes the
// expected outputs per byte and they are compared once the byte has been decoded.
module tb_kbd_key_tracker;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_next_n;
    logic [7:0] data_out;
    logic       pre;
    logic [7:0] ascii_out;
    logic [7:0] count;
    logic       capslock;
    logic       shift;

    kbd_key_tracker dut (
        .clk       (clk),
        .clrn      (clrn),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .rx_next_n (rx_next_n),
        .data_out  (data_out),
        .pre       (pre),
        .ascii_out (ascii_out),
        .count     (count),
        .capslock  (capslock),
        .shift     (shift)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       pre;
        logic [7:0] ascii;
        logic [7:0] count;
        logic       caps;
        logic       shift;
    } exp_t;

    logic [7:0] fifo[$];
    exp_t       exp_q[$];
    int         errors = 0;
    int         checks = 0;
    int         pops = 0;
    int         due = 0;
    int         pops_before;

    // Reference model state.
    logic [7:0] m_key, m_data, m_count;
    logic       m_pre, m_brk, m_ext, m_caps, m_ls, m_rs;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_ascii(input logic [7:0] k);
        case (k)
            8'h1C: return 8'h61;
            8'h32: return 8'h62;
            8'h15: return 8'h71;
            8'h29: return 8'h20;
            8'h45: return 8'h30;
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_reset();
        m_key = 0; m_data = 0; m_count = 0;
        m_pre = 0; m_brk = 0; m_ext = 0; m_caps = 0; m_ls = 0; m_rs = 0;
    endtask

    task automatic model(input logic [7:0] b);
        exp_t e;
        if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
            m_data = 8'hF0;
        end else if (m_brk) begin
            m_data = (b == m_key) ? b : m_key;
            if (b == m_key) m_pre = 0;
            if (!m_ext && b == 8'h12) m_ls = 0;
            if (!m_ext && b == 8'h59) m_rs = 0;
            m_brk = 0;
            m_ext = 0;
        end else begin
            m_data = b;
            if (!(m_pre && b == m_key)) begin
                m_key = b;
                m_pre = 1;
                m_count = (m_count == 8'd99) ? 8'd0 : m_count + 8'd1;
                if (b == 8'h58) m_caps = !m_caps;
            end
            if (!m_ext && b == 8'h12) m_ls = 1;
            if (!m_ext && b == 8'h59) m_rs = 1;
            m_ext = 0;
        end
        e.data = m_data; e.pre = m_pre; e.ascii = m_ascii(m_key);
        e.count = m_count; e.caps = m_caps; e.shift = m_ls | m_rs;
        exp_q.push_back(e);
    endtask

    task automatic compare();
        exp_t e;
        if (exp_q.size() == 0) begin
            chk("scoreboard_underflow", 8'd1, 8'd0);
        end else begin
            e = exp_q.pop_front();
            chk("data_out", data_out, e.data);
            chk("pre", pre, e.pre);
            chk("ascii_out", ascii_out, e.ascii);
            chk("count", count, e.count);
            chk("capslock", capslock, e.caps);
            chk("shift", shift, e.shift);
        end
    endtask

    // One clock: compare decoded bytes, service pops, refresh the FIFO head.
    task automatic cyc();
        @(negedge clk);
        if (due != 0) begin
            due--;
            if (due == 1) chk("strobe_one_cycle", rx_next_n, 1'b1);
            if (due == 0) compare();
        end
        if (!rx_next_n) begin
            pops++;
            if (fifo.size() != 0) void'(fifo.pop_front());
            else chk("pop_when_empty", 8'd1, 8'd0);
            due = 2;
        end
        rx_ready = (fifo.size() != 0);
        rx_data  = rx_ready ? fifo[0] : 8'h00;
    endtask

    task automatic feed(input logic [7:0] b);
        fifo.push_back(b);
        model(b);
        rx_ready = 1'b1;
        rx_data  = fifo[0];
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while ((fifo.size() != 0 || due != 0) && n < bound) begin
            cyc();
            n++;
        end
        repeat (2) cyc();
        chk("drain_in_time", 8'(n < bound), 8'd1);
        chk("scoreboard_empty", 8'(exp_q.size()), 8'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        clrn = 1'b0;
        fifo.delete();
        exp_q.delete();
        due = 0;
        rx_ready = 1'b0;
        rx_data = 8'h00;
        model_reset();
        #2;
        chk("rst_rx_next_n", rx_next_n, 1'b1);
        chk("rst_data_out", data_out, 8'h00);
        chk("rst_pre", pre, 1'b0);
        chk("rst_count", count, 8'h00);
        chk("rst_caps", capslock, 1'b0);
        chk("rst_shift", shift, 1'b0);
        chk("rst_ascii", ascii_out, 8'h00);
        @(negedge clk);
        clrn = 1'b1;
    endtask

    initial begin
        model_reset();
        do_reset();

        // 1: single make, one pop strobe
        pops_before = pops;
        feed(8'h1C);
        drain(20);
        chk("t1_pops", 8'(pops - pops_before), 8'd1);
        chk("t1_ascii", ascii_out, 8'h61);

        // 2: typematic repeats then release
        feed(8'h1C); feed(8'h1C); feed(8'h1C); feed(8'hF0); feed(8'h1C);
        drain(40);
        chk("t2_count", count, 8'd1);
        chk("t2_pre", pre, 1'b0);

        // 3: shift held around a letter
        do_reset();
        feed(8'h12); feed(8'h1C); feed(8'hF0); feed(8'h12);
        drain(40);
        chk("t3_count", count, 8'd2);
        chk("t3_shift", shift, 1'b0);
        chk("t3_pre", pre, 1'b1);

        // 4: caps-lock toggling and fake shift
        do_reset();
        feed(8'h58); feed(8'hF0); feed(8'h58); feed(8'h58); feed(8'h58); feed(8'hF0); feed(8'h58);
        feed(8'hE0); feed(8'h12);
        drain(60);
        chk("t4_caps", capslock, 1'b0);
        chk("t4_shift", shift, 1'b0);

        // 5: counter wrap, then release of a non-held key
        do_reset();
        for (int i = 0; i < 100; i++) begin
            feed((i % 2 == 0) ? 8'h1C : 8'h32);
            feed(8'hF0);
            feed((i % 2 == 0) ? 8'h1C : 8'h32);
        end
        drain(1200);
        chk("t5_wrap", count, 8'd0);
        feed(8'h1C); feed(8'h32); feed(8'hF0); feed(8'h1C);
        drain(40);
        chk("t5_data", data_out, 8'h32);
        chk("t5_pre", pre, 1'b1);

        // 6: continuous FIFO, then reset with a break pending
        pops_before = pops;
        feed(8'h15); feed(8'h29); feed(8'h45); feed(8'hF0); feed(8'h45); feed(8'h1C);
        drain(60);
        chk("t6_pops", 8'(pops - pops_before), 8'd6);
        feed(8'hF0);
        drain(20);
        do_reset();
        feed(8'h1C);
        drain(20);
        chk("t6_count", count, 8'd1);
        chk("t6_pre", pre, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
